// File: rtl/ram_reader.sv
// -----------------------------------------------------------------------------
// ram_reader
//   Streams back every word of a RAM that has been filled earlier, for example
//   by a ROM-to-RAM copy. The block walks the SIZE = 2**ADDR_WIDTH addresses in
//   order and presents each word on a valid/ready port. It also keeps a running
//   checksum, which is the sum of the accepted words modulo 2**DATA_WIDTH.
//   finish pulses for one cycle after the last word has been accepted.
//
//   The RAM read port has a registered read with 1-cycle latency. Each word
//   therefore passes through three states: FETCH presents the address, LATCH
//   captures the returned data, and SEND offers the word to the sink.
//
// Ports
//   i_clk        system clock, rising edge
//   i_reset      synchronous reset, active low
//   i_start      begins a read pass; sampled only while idle
//   o_rd_addr    RAM read address (driven only in FETCH and LATCH, else 0)
//   i_rd_data    RAM read data, valid one cycle after o_rd_addr
//   o_out_data   streamed word, stable while o_out_valid is high
//   o_out_valid  o_out_data is valid
//   i_out_ready  sink accepts the word when o_out_valid && i_out_ready
//   o_busy       high in every state except IDLE
//   o_finish     1-cycle pulse after the last word is accepted
//   o_checksum   sum of the accepted words, modulo 2**DATA_WIDTH
// -----------------------------------------------------------------------------
module ram_reader #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic                  o_busy,
    output logic                  o_finish,
    output logic [DATA_WIDTH-1:0] o_checksum
);

    localparam int SIZE = 2 ** ADDR_WIDTH;
    // The word counter is one bit wider than the RAM address. This keeps the
    // last-word compare from aliasing when the counter wraps.
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(SIZE - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_addr;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_busy;
    logic                  r_finish;
    logic [DATA_WIDTH-1:0] r_checksum;
    logic [ADDR_WIDTH:0]   w_addr_inc;

    assign w_addr_inc = r_addr + 1'b1;

    // Every output comes from a register. Each output is loaded on the edge
    // that enters the state in which it must be visible. As a result,
    // i_out_ready only affects the next state and never feeds an output
    // combinationally.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_rd_addr   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_finish    <= 1'b0;
            r_checksum  <= '0;
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                IDLE: begin
                    // The checksum of the previous pass stays readable until
                    // the next start clears it.
                    if (i_start) begin
                        r_addr     <= '0;
                        r_checksum <= '0;
                        r_rd_addr  <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= FETCH;
                    end
                end
                FETCH: begin
                    // The address is on the RAM port during this cycle. The
                    // RAM registers the data at the end of this cycle.
                    r_state <= LATCH;
                end
                LATCH: begin
                    r_out_data  <= i_rd_data;
                    r_out_valid <= 1'b1;
                    r_rd_addr   <= '0;
                    r_state     <= SEND;
                end
                SEND: begin
                    if (i_out_ready) begin
                        r_checksum  <= r_checksum + r_out_data;
                        r_out_valid <= 1'b0;
                        if (r_addr == LAST_ADDR) begin
                            r_finish <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_addr    <= w_addr_inc;
                            r_rd_addr <= w_addr_inc[ADDR_WIDTH-1:0];
                            r_state   <= FETCH;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_rd_addr   <= '0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign o_rd_addr   = r_rd_addr;
    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_busy      = r_busy;
    assign o_finish    = r_finish;
    assign o_checksum  = r_checksum;

endmodule

// File: tb/tb_ram_reader.sv
// -----------------------------------------------------------------------------
// tb_ram_reader
//   Bench for ram_reader with ADDR_WIDTH=2 and DATA_WIDTH=8. A RAM model with a
//   1-cycle registered read feeds the DUT. For each pass, the reference model
//   builds a queue of the words expected from the RAM contents. It also
//   computes the expected checksum as the plain sum of those words, modulo 256.
//   Outputs are sampled on the falling edge. Inputs are driven on the falling
//   edge as well.
// -----------------------------------------------------------------------------
module tb_ram_reader;

    localparam int AW   = 2;
    localparam int DW   = 8;
    localparam int SIZE = 4;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          finish;
    logic [DW-1:0] checksum;

    logic [DW-1:0] mem [SIZE];

    int n_checks = 0;
    int n_errors = 0;

    ram_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .o_rd_addr   (rd_addr),
        .i_rd_data   (rd_data),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_busy      (busy),
        .o_finish    (finish),
        .o_checksum  (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM read port with one cycle of registered latency
    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},     32'(busy),      0);
        check({tag, "_valid"},    32'(out_valid), 0);
        check({tag, "_finish"},   32'(finish),    0);
        check({tag, "_rd_addr"},  32'(rd_addr),   0);
        check({tag, "_checksum"}, 32'(checksum),  0);
    endtask

    // mode 0: sink always ready (also checks exact cycle timing)
    // mode 1: sink stalls 5 cycles while word 1 is presented
    // mode 2: sink ready about 60 percent of the time
    // mode 3: always ready, plus a start pulse while word 1 is in SEND
    task automatic run_pass(input int mode);
        logic [DW-1:0] exp_q [$];
        int exp_sum   = 0;
        int model_sum = 0;
        int accepted  = 0;
        int finishes  = 0;
        int cyc       = 0;
        int last_hs   = -1;
        int stall     = 5;
        bit fin_seen  = 0;
        bit restarted = 0;
        bit done      = 0;
        bit rdy;

        for (int i = 0; i < SIZE; i++) begin
            exp_q.push_back(mem[i]);
            exp_sum += int'(mem[i]);
        end
        exp_sum = exp_sum % 256;

        start     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            rdy   = 1'b1;
            if (fin_seen) begin
                check("busy_after_done", 32'(busy), 0);
                done = 1;
            end else begin
                check("busy_in_pass", 32'(busy), 1);
                if (finish) begin
                    finishes++;
                    fin_seen = 1;
                    check("finish_checksum", 32'(checksum), 32'(exp_sum));
                    check("finish_words",    32'(accepted), SIZE);
                    check("finish_after_hs", 32'(cyc),      32'(last_hs + 1));
                    $display("pass mode %0d: finish at cycle %0d checksum %02h", mode, cyc, checksum);
                end else if (out_valid) begin
                    check("send_rd_addr",  32'(rd_addr),  0);
                    check("send_checksum", 32'(checksum), 32'(model_sum));
                    if (exp_q.size() == 0)
                        check("extra_word", 1, 0);
                    else
                        check("word_data", 32'(out_data), 32'(exp_q[0]));
                    if (mode == 0 || mode == 3)
                        check("word_cycle", 32'(cyc), 32'(3 + 3 * accepted));
                    if (mode == 1 && accepted == 1 && stall > 0) begin
                        rdy = 1'b0;
                        stall--;
                    end
                    if (mode == 2)
                        rdy = ($urandom_range(0, 99) < 60);
                    if (mode == 3 && accepted == 1 && !restarted) begin
                        start     = 1'b1;
                        restarted = 1;
                    end
                    if (rdy && exp_q.size() > 0) begin
                        $display("word %0d: data %02h", accepted, exp_q[0]);
                        model_sum = (model_sum + int'(exp_q.pop_front())) % 256;
                        accepted++;
                        last_hs = cyc;
                    end
                end else begin
                    // FETCH/LATCH: the address of the word about to be fetched
                    check("fetch_rd_addr", 32'(rd_addr), 32'(accepted));
                end
            end
            out_ready = rdy;
        end
        check("pass_terminated", 32'(done),     1);
        check("finish_once",     32'(finishes), 1);
        out_ready = 1'b0;
        start     = 1'b0;
    endtask

    initial begin
        int valids;
        reset     = 1'b0;
        start     = 1'b1;
        out_ready = 1'b0;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

        // Test 1: reset held for 2 cycles while start is high
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_idle_outputs("reset");
        end
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Test 2: basic pass, sink always ready
        run_pass(0);
        repeat (3) @(negedge clk);
        check("idle_hold_AA", 32'(checksum), 32'h0000_00AA);

        // Test 3: sink stall while 22h is presented
        run_pass(1);

        // Test 4: start pulse during SEND of word 1 is ignored
        run_pass(3);

        // Test 5: reset during SEND of word 2
        start     = 1'b1;
        out_ready = 1'b1;
        valids    = 0;
        for (int k = 0; k < 50 && valids < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid) valids++;
        end
        check("reached_word2", 32'(valids), 3);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_idle_outputs("mid_reset");
        check("mid_reset_data", 32'(out_data), 0);
        @(negedge clk);
        run_pass(0);

        // Test 6: checksum wrap-around
        mem[0] = 8'hFF; mem[1] = 8'hFF; mem[2] = 8'h01; mem[3] = 8'h02;
        run_pass(0);
        repeat (4) @(negedge clk);
        check("wrap_hold", 32'(checksum), 32'h0000_0001);

        // Randomized contents and sink behaviour
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < SIZE; i++) mem[i] = DW'($urandom);
            run_pass((p % 3 == 0) ? 0 : 2);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
